decoder_scan_seq: RTL
=====================

# decoder_scan_seq

Registered scan sequencer that drives the select (`x[2:0]`) and enable (`en`) inputs of the 3-to-8 decoder `Decoder2`. It steps through the eight decoder outputs in ascending order, skips masked-off channels, and holds each channel for a programmable number of cycles. It runs as a single pass or continuously, and reports `busy`, `done` and `wrap` status to the controlling logic. It sits directly upstream of the decoder: `x` and `en` connect port-for-port.

## Interface
- `DWELL_W`, default 8: width of the dwell-count input and the internal dwell counter.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset, asynchronous, active-high; forces every register to its reset value immediately.
- `start`  input  1  level-sampled request to begin a scan; honoured only in IDLE.
- `stop`  input  1  aborts a running scan.
- `mode`  input  1  0 = single pass, 1 = continuous.
- `mask`  input  8  channel enable; bit n=1 means channel n is visited.
- `dwell`  input  DWELL_W  cycles spent on each visited channel; a value of 0 is treated as 1.
- `x`  output  3  decoder select (current channel).
- `en`  output  1  decoder enable.
- `busy`  output  1  high while in SCAN.
- `done`  output  1  one-cycle pulse when a single pass completes.
- `wrap`  output  1  one-cycle pulse when a continuous scan restarts from the lowest channel.

## Operation
- States: IDLE and SCAN. All outputs are registered, with no combinational path from inputs to outputs.
- IDLE outputs: `x`=0, `en`=0, `busy`=0.
- Start is accepted on an edge where all of these hold: state is IDLE, `start`=1, `stop`=0, and `mask`≠0.
  - On that edge, `mask`, `dwell` and `mode` are captured into shadow registers. Input changes during a scan have no effect.
  - Next state is SCAN. `x` is set to the lowest set bit of the captured mask, `en`=1, `busy`=1, and the dwell counter is loaded.
- If `start`=1 with `mask`=0, the request is ignored: the block stays in IDLE and no pulse is issued.
- Each visited channel holds `x` stable with `en`=1 for exactly D cycles, where D = max(captured `dwell`, 1).
- On the last dwell cycle, the next channel is the lowest set mask bit strictly above `x`.
  - If one exists, `x` jumps directly to it. Skipped channels consume no cycles, and `en` stays high across the change.
  - If none exists and `mode`=0: go to IDLE (`x`=0, `en`=0, `busy`=0) and pulse `done` in that first IDLE cycle.
  - If none exists and `mode`=1: move to the lowest set bit and pulse `wrap` during the first cycle on that channel.
  - With a single enabled channel in continuous mode, `x` stays constant and `wrap` pulses once every D cycles.
- `stop`=1 in SCAN:
  - Next state is IDLE, with `x`=0, `en`=0, `busy`=0.
  - No `done` and no `wrap` are issued, even if the stop coincides with the final dwell cycle.
- `start`=1 in SCAN is ignored. `stop` in IDLE has no effect.
- The dwell counter is DWELL_W bits wide and counts down to 1. It never underflows or wraps.

## Timing
- Reset values: `x`=0, `en`=0, `busy`=0, `done`=0, `wrap`=0, state IDLE, counter 0, shadow registers 0.
  - Asserting reset mid-scan clears outputs asynchronously, without waiting for `clk`.
  - The first start can be accepted on the first rising edge after reset deasserts.
- Start latency: with `start` sampled at edge k, `en`=1 and the first `x` are valid after edge k.
- Single-pass length: N·D cycles with `en`=1, where N = popcount(mask). `done` is high for the single cycle after the last `en`=1 cycle.
- A new `start` can be accepted on the same edge where `done` is high, giving back-to-back passes with a single `en`=0 cycle between them.
- `done` and `wrap` are never high in the same cycle. Each is exactly one cycle wide.

## Test plan
- Reset, then `start` with `mask`=8'hFF, `dwell`=1, `mode`=0 → `x` = 0,1,…,7 on consecutive cycles with `en`=1; then `en`=0, `x`=0, and `done`=1 for one cycle. The decoder's `D` walks 00000001 through 10000000.
- `mask`=8'b1010_0100, `dwell`=3, `mode`=0 → `x`=2 for 3 cycles, `x`=5 for 3 cycles, `x`=7 for 3 cycles; then `done`. This is 9 cycles total with `en`=1.
- `mask`=8'h81, `dwell`=2, `mode`=1 for 10 cycles → `x` sequence 0,0,7,7,0,0,7,7,0,0; `wrap` high on cycles 5 and 9; `done` never asserts.
- Continuous scan, with `stop` asserted on the final cycle of channel 7 → next cycle is IDLE with `en`=0 and `busy`=0, and neither `wrap` nor `done` pulses. `mask`=0 with `start` → the block stays in IDLE.
- `dwell`=0 behaves identically to `dwell`=1. Changing `mask` or `dwell` mid-scan does not alter the running pass. `start` held high through a pass → a new pass begins on the `done` cycle.
- Assert `rst` asynchronously mid-dwell on channel 4 → all outputs are 0 before the next `clk` edge. After release, a new `start` behaves as in the first scenario.

Source files
------------

// File: rtl/decoder_scan_seq.sv
// rtl/decoder_scan_seq.sv - registered channel scan sequencer driving a 3-to-8 decoder
module decoder_scan_seq #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         x,
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    localparam logic [DWELL_W-1:0] DWELL_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] DWELL_ZERO = '0;

    state_t               state_q, state_d;
    logic [2:0]           x_q, x_d;
    logic                 en_q, en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 wrap_q, wrap_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [7:0]           mask_q, mask_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic                 mode_q, mode_d;

    logic [DWELL_W-1:0]   dwell_eff;
    logic [2:0]           start_ch;
    logic [2:0]           first_ch;
    logic [2:0]           next_ch;
    logic                 next_found;

    // A dwell of zero is treated as a single cycle so every channel is visible
    assign dwell_eff = (dwell == DWELL_ZERO) ? DWELL_ONE : dwell;

    // Priority pick: lowest set bit of the live mask, lowest of the shadow mask,
    // and lowest shadow bit strictly above the current channel
    always_comb begin
        start_ch   = 3'd0;
        first_ch   = 3'd0;
        next_ch    = 3'd0;
        next_found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                start_ch = 3'(i);
            end
            if (mask_q[i]) begin
                first_ch = 3'(i);
            end
            if (mask_q[i] && (i > int'(x_q))) begin
                next_ch    = 3'(i);
                next_found = 1'b1;
            end
        end
    end

    // Next-state and registered-output decisions for the IDLE/SCAN machine
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                x_d    = 3'd0;
                en_d   = 1'b0;
                busy_d = 1'b0;
                if (start && !stop && (mask != 8'd0)) begin
                    state_d = S_SCAN;
                    mask_d  = mask;
                    dwell_d = dwell_eff;
                    mode_d  = mode;
                    cnt_d   = dwell_eff;
                    x_d     = start_ch;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_SCAN: begin
                if (stop) begin
                    // Abort wins over any end-of-pass or wrap event
                    state_d = S_IDLE;
                    x_d     = 3'd0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = DWELL_ZERO;
                end else if (cnt_q <= DWELL_ONE) begin
                    if (next_found) begin
                        x_d   = next_ch;
                        cnt_d = dwell_q;
                    end else if (mode_q) begin
                        x_d    = first_ch;
                        wrap_d = 1'b1;
                        cnt_d  = dwell_q;
                    end else begin
                        state_d = S_IDLE;
                        x_d     = 3'd0;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        cnt_d   = DWELL_ZERO;
                    end
                end else begin
                    cnt_d = cnt_q - DWELL_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                x_d     = 3'd0;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, outputs, dwell counter and shadow registers with async reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= 3'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= DWELL_ZERO;
            mask_q  <= 8'd0;
            dwell_q <= DWELL_ZERO;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
            mode_q  <= mode_d;
        end
    end

    assign x    = x_q;
    assign en   = en_q;
    assign busy = busy_q;
    assign done = done_q;
    assign wrap = wrap_q;

endmodule
